// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the game-state packet transmitter.
//   - Grid geometry and the grid_t cell array type (4 bits per cell).
//   - Packet format constants: header byte, packet length and the byte
//     offsets where the object grid, timer grid and checksum begin.
//   - tx_state_t sequencer states and snapshot_t, the registered image of
//     every game-state input that one packet carries.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 13;

    localparam logic [7:0]  HEADER  = 8'hA5;
    localparam int unsigned PKT_LEN = 122;

    localparam logic [6:0] OFS_OBJ  = 7'd17;
    localparam logic [6:0] OFS_TIME = 7'd69;
    localparam logic [6:0] OFS_CHK  = 7'd121;

    // Cell (row, col) sits at bit offset (row*13 + col)*4, so the same bits
    // viewed as bytes give {cell[2j+1], cell[2j]} in byte j.
    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0][3:0] grid_t;
    typedef logic [GRID_ROWS*GRID_COLS/2-1:0][7:0]   grid_bytes_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    typedef struct packed {
        logic [1:0]       player_id;
        logic [2:0]       game_state;
        grid_t            object_grid;
        grid_t            time_grid;
        logic [7:0]       time_left;
        logic [9:0]       point_total;
        logic [3:0]       orders;
        logic [3:0][4:0]  order_times;
        logic [2:0][7:0]  team_name;
        logic [1:0]       player_direction;
        logic [8:0]       player_loc_x;
        logic [8:0]       player_loc_y;
        logic [3:0]       player_state;
    } snapshot_t;

endpackage

// File: rtl/game_state_tx_if.sv
// ---------------------------------------------------------------------------
// game_state_tx_if
// Byte-wide valid/ready stream from the packet transmitter to the link.
//   tx_data  : stream byte (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : slave accepts the byte when tx_valid && tx_ready
// ---------------------------------------------------------------------------
interface game_state_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/packet_byte_mux.sv
// ---------------------------------------------------------------------------
// packet_byte_mux
// Purely combinational: selects packet byte 'index' out of the held
// snapshot. Byte 121 is the running checksum supplied by the sequencer.
//   snap      : registered game-state snapshot
//   index     : byte position 0..121
//   checksum  : XOR of bytes 1..120 accumulated so far
//   byte_out  : selected byte
// ---------------------------------------------------------------------------
module packet_byte_mux
    import game_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  snapshot_t  snap,
    input  logic [6:0] index,
    input  logic [7:0] checksum,
    output logic [7:0] byte_out
);

    grid_bytes_t obj_bytes;
    grid_bytes_t time_bytes;
    logic [5:0]  obj_j;
    logic [5:0]  time_j;

    assign obj_bytes  = snap.object_grid;
    assign time_bytes = snap.time_grid;

    always_comb begin
        byte_out = 8'h00;
        obj_j    = 6'(index - OFS_OBJ);
        time_j   = 6'(index - OFS_TIME);
        if (index >= OFS_CHK) begin
            byte_out = checksum;
        end else if (index >= OFS_TIME) begin
            byte_out = time_bytes[time_j];
        end else if (index >= OFS_OBJ) begin
            byte_out = obj_bytes[obj_j];
        end else begin
            case (index)
                7'd0:    byte_out = HEADER_BYTE;
                7'd1:    byte_out = {snap.player_id, snap.game_state, 3'b000};
                7'd2:    byte_out = {snap.player_direction, snap.player_state,
                                     1'b0, snap.player_loc_x[8]};
                7'd3:    byte_out = snap.player_loc_x[7:0];
                7'd4:    byte_out = {7'b0, snap.player_loc_y[8]};
                7'd5:    byte_out = snap.player_loc_y[7:0];
                7'd6:    byte_out = snap.time_left;
                7'd7:    byte_out = {6'b0, snap.point_total[9:8]};
                7'd8:    byte_out = snap.point_total[7:0];
                7'd9:    byte_out = {4'b0, snap.orders};
                7'd10:   byte_out = {3'b0, snap.order_times[0]};
                7'd11:   byte_out = {3'b0, snap.order_times[1]};
                7'd12:   byte_out = {3'b0, snap.order_times[2]};
                7'd13:   byte_out = {3'b0, snap.order_times[3]};
                7'd14:   byte_out = snap.team_name[2];
                7'd15:   byte_out = snap.team_name[1];
                7'd16:   byte_out = snap.team_name[0];
                default: byte_out = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/game_state_tx.sv
// ---------------------------------------------------------------------------
// game_state_tx
// Snapshots the full game state on a send request (or an internal auto tick)
// and streams it as a fixed 122-byte checksummed packet.
//   clock, reset       : system clock, synchronous active-high reset
//   send               : level request for a snapshot + transmit
//   local_player_ID .. player_state : live game-state inputs
//   tx (master)        : byte stream tx_data/tx_valid/tx_ready
//   busy               : packet in progress, snapshot held
//   pkt_done           : one-cycle pulse after the checksum byte is accepted
//   overrun            : sticky, a request arrived while busy
// ---------------------------------------------------------------------------
module game_state_tx
    import game_pkg::*;
#(
    parameter int unsigned PKT_LEN     = game_pkg::PKT_LEN,
    parameter logic [7:0]  HEADER      = game_pkg::HEADER,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            send,
    input  logic [1:0]      local_player_ID,
    input  logic [2:0]      game_state,
    input  grid_t           object_grid,
    input  grid_t           time_grid,
    input  logic [7:0]      time_left,
    input  logic [9:0]      point_total,
    input  logic [3:0]      orders,
    input  logic [3:0][4:0] order_times,
    input  logic [2:0][7:0] team_name,
    input  logic [1:0]      player_direction,
    input  logic [8:0]      player_loc_x,
    input  logic [8:0]      player_loc_y,
    input  logic [3:0]      player_state,
    game_state_tx_if.master tx,
    output logic            busy,
    output logic            pkt_done,
    output logic            overrun
);

    localparam logic [6:0]  LAST_IDX  = 7'(PKT_LEN - 1);
    localparam logic [31:0] AUTO_LAST = (AUTO_PERIOD == 0) ? 32'd0 : 32'(AUTO_PERIOD - 1);

    tx_state_t  state;
    snapshot_t  snap;
    logic [6:0] byte_idx;
    logic [7:0] checksum;
    logic [7:0] cur_byte;
    logic [31:0] auto_cnt;
    logic       auto_tick;
    logic       req;
    logic       sending;

    // Free-running auto-send counter; it keeps counting while a packet is in
    // flight so ticks that land mid-packet are reported as overruns.
    always_comb begin
        auto_tick = (AUTO_PERIOD != 0) && (auto_cnt == AUTO_LAST);
        req       = send | auto_tick;
    end

    always_ff @(posedge clock) begin
        if (reset || auto_tick || AUTO_PERIOD == 0) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 32'd1;
        end
    end

    packet_byte_mux #(
        .HEADER_BYTE (HEADER)
    ) u_mux (
        .snap     (snap),
        .index    (byte_idx),
        .checksum (checksum),
        .byte_out (cur_byte)
    );

    // Stream outputs come straight from registered state, so they are
    // inherently stable while the sink stalls.
    always_comb begin
        sending     = (state == SEND);
        tx.tx_valid = sending;
        tx.tx_data  = sending ? cur_byte : 8'h00;
        busy        = sending;
    end

    // Sequencer: capture the snapshot on a request in IDLE, then step the
    // byte index on each handshake, folding bytes 1..120 into the checksum.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            snap     <= '0;
            byte_idx <= '0;
            checksum <= '0;
            pkt_done <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (state == IDLE) begin
                if (req) begin
                    snap.player_id        <= local_player_ID;
                    snap.game_state       <= game_state;
                    snap.object_grid      <= object_grid;
                    snap.time_grid        <= time_grid;
                    snap.time_left        <= time_left;
                    snap.point_total      <= point_total;
                    snap.orders           <= orders;
                    snap.order_times      <= order_times;
                    snap.team_name        <= team_name;
                    snap.player_direction <= player_direction;
                    snap.player_loc_x     <= player_loc_x;
                    snap.player_loc_y     <= player_loc_y;
                    snap.player_state     <= player_state;
                    byte_idx              <= '0;
                    checksum              <= '0;
                    state                 <= SEND;
                end
            end else begin
                if (req) begin
                    overrun <= 1'b1;
                end
                if (tx.tx_ready) begin
                    if (byte_idx == LAST_IDX) begin
                        byte_idx <= '0;
                        pkt_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        byte_idx <= byte_idx + 7'd1;
                        if (byte_idx != 7'd0) begin
                            checksum <= checksum ^ cur_byte;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_state_tx.sv
// ---------------------------------------------------------------------------
// tb_game_state_tx
// Directed self-checking bench for game_state_tx. One manual-send DUT is
// driven through the directed steps; two auto-send DUTs (periods 200 and
// 100) check packet spacing and overrun behaviour.
// ---------------------------------------------------------------------------
module tb_game_state_tx;
    import game_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic            auto_reset;
    logic            send;
    logic [1:0]      local_player_ID;
    logic [2:0]      game_state;
    grid_t           object_grid;
    grid_t           time_grid;
    logic [7:0]      time_left;
    logic [9:0]      point_total;
    logic [3:0]      orders;
    logic [3:0][4:0] order_times;
    logic [2:0][7:0] team_name;
    logic [1:0]      player_direction;
    logic [8:0]      player_loc_x;
    logic [8:0]      player_loc_y;
    logic [3:0]      player_state;

    logic busy, pkt_done, overrun;
    logic a200_busy, a200_done, a200_overrun;
    logic a100_busy, a100_done, a100_overrun;

    game_state_tx_if tx_bus ();
    game_state_tx_if a200_bus ();
    game_state_tx_if a100_bus ();

    logic [7:0] got     [0:121];
    logic [7:0] exp_pkt [0:121];
    int vectors    = 0;
    int miscompares = 0;

    game_state_tx dut (
        .clock (clock), .reset (reset), .send (send),
        .local_player_ID (local_player_ID), .game_state (game_state),
        .object_grid (object_grid), .time_grid (time_grid),
        .time_left (time_left), .point_total (point_total),
        .orders (orders), .order_times (order_times), .team_name (team_name),
        .player_direction (player_direction), .player_loc_x (player_loc_x),
        .player_loc_y (player_loc_y), .player_state (player_state),
        .tx (tx_bus), .busy (busy), .pkt_done (pkt_done), .overrun (overrun)
    );

    game_state_tx #(.AUTO_PERIOD (200)) dut_a200 (
        .clock (clock), .reset (auto_reset), .send (1'b0),
        .local_player_ID (local_player_ID), .game_state (game_state),
        .object_grid (object_grid), .time_grid (time_grid),
        .time_left (time_left), .point_total (point_total),
        .orders (orders), .order_times (order_times), .team_name (team_name),
        .player_direction (player_direction), .player_loc_x (player_loc_x),
        .player_loc_y (player_loc_y), .player_state (player_state),
        .tx (a200_bus), .busy (a200_busy), .pkt_done (a200_done), .overrun (a200_overrun)
    );

    game_state_tx #(.AUTO_PERIOD (100)) dut_a100 (
        .clock (clock), .reset (auto_reset), .send (1'b0),
        .local_player_ID (local_player_ID), .game_state (game_state),
        .object_grid (object_grid), .time_grid (time_grid),
        .time_left (time_left), .point_total (point_total),
        .orders (orders), .order_times (order_times), .team_name (team_name),
        .player_direction (player_direction), .player_loc_x (player_loc_x),
        .player_loc_y (player_loc_y), .player_state (player_state),
        .tx (a100_bus), .busy (a100_busy), .pkt_done (a100_done), .overrun (a100_overrun)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_inputs();
        local_player_ID  = '0; game_state   = '0;
        object_grid      = '0; time_grid    = '0;
        time_left        = '0; point_total  = '0;
        orders           = '0; order_times  = '0;
        team_name        = '0; player_direction = '0;
        player_loc_x     = '0; player_loc_y = '0;
        player_state     = '0;
    endtask

    task automatic scramble_inputs();
        local_player_ID  = 2'($urandom);
        game_state       = 3'($urandom);
        time_left        = 8'($urandom);
        point_total      = 10'($urandom);
        orders           = 4'($urandom);
        for (int i = 0; i < 4; i++) order_times[i] = 5'($urandom);
        for (int i = 0; i < 3; i++) team_name[i] = 8'($urandom);
        player_direction = 2'($urandom);
        player_loc_x     = 9'($urandom);
        player_loc_y     = 9'($urandom);
        player_state     = 4'($urandom);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 13; c++) begin
                object_grid[r][c] = 4'($urandom);
                time_grid[r][c]   = 4'($urandom);
            end
        end
    endtask

    // Reference packet built from the current bench inputs.
    function automatic void build_expected();
        logic [7:0] chk;
        int n0, n1;
        exp_pkt[0] = 8'hA5;
        exp_pkt[1] = {local_player_ID, game_state, 3'b000};
        exp_pkt[2] = {player_direction, player_state, 1'b0, player_loc_x[8]};
        exp_pkt[3] = player_loc_x[7:0];
        exp_pkt[4] = {7'b0, player_loc_y[8]};
        exp_pkt[5] = player_loc_y[7:0];
        exp_pkt[6] = time_left;
        exp_pkt[7] = {6'b0, point_total[9:8]};
        exp_pkt[8] = point_total[7:0];
        exp_pkt[9] = {4'b0, orders};
        for (int i = 0; i < 4; i++) exp_pkt[10+i] = {3'b0, order_times[i]};
        exp_pkt[14] = team_name[2];
        exp_pkt[15] = team_name[1];
        exp_pkt[16] = team_name[0];
        for (int j = 0; j < 52; j++) begin
            n0 = 2 * j;
            n1 = n0 + 1;
            exp_pkt[17+j] = {object_grid[n1/13][n1%13], object_grid[n0/13][n0%13]};
            exp_pkt[69+j] = {time_grid[n1/13][n1%13], time_grid[n0/13][n0%13]};
        end
        chk = 8'h00;
        for (int i = 1; i <= 120; i++) chk = chk ^ exp_pkt[i];
        exp_pkt[121] = chk;
    endfunction

    task automatic start_packet(input string tag);
        send = 1'b1;
        step();
        send = 1'b0;
        check({tag, "_lat_valid"}, 32'(tx_bus.tx_valid), 32'd1);
        check({tag, "_lat_hdr"}, 32'(tx_bus.tx_data), 32'hA5);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1-0-0-1.
    // change_at: byte index at which inputs are scrambled and send pulsed.
    task automatic get_packet(input int mode, input int change_at, input int stop_at);
        int idx, cycles;
        logic prev_stalled, rdy, changed;
        logic [7:0] prev_data;
        idx = 0; cycles = 0; prev_stalled = 1'b0; prev_data = 8'h00; changed = 1'b0;
        while (idx < stop_at && cycles < 2000) begin
            if (prev_stalled) begin
                check("hold_valid", 32'(tx_bus.tx_valid), 32'd1);
                check("hold_data", 32'(tx_bus.tx_data), 32'(prev_data));
            end
            if (idx == change_at && !changed) begin
                scramble_inputs();
                send = 1'b1;
                changed = 1'b1;
            end else begin
                send = 1'b0;
            end
            rdy = (mode == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
            tx_bus.tx_ready = rdy;
            if (tx_bus.tx_valid && rdy) begin
                got[idx] = tx_bus.tx_data;
                idx++;
            end
            prev_stalled = tx_bus.tx_valid && !rdy;
            prev_data    = tx_bus.tx_data;
            step();
            cycles++;
        end
        send = 1'b0;
        tx_bus.tx_ready = 1'b0;
        check("pkt_len", 32'(idx), 32'(stop_at));
        if (mode == 0 && stop_at == 122) check("pkt_cycles", 32'(cycles), 32'd122);
    endtask

    task automatic compare_packet(input string tag);
        for (int i = 0; i < 122; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_pkt[i]));
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, 32'(pkt_done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_valid_low"}, 32'(tx_bus.tx_valid), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(pkt_done), 32'd0);
    endtask

    initial begin
        int n200, n100;
        int s200 [0:2];
        int s100 [0:2];
        logic p200, p100;

        reset = 1'b1; auto_reset = 1'b1; send = 1'b0;
        tx_bus.tx_ready = 1'b0; a200_bus.tx_ready = 1'b1; a100_bus.tx_ready = 1'b1;
        zero_inputs();
        repeat (3) step();

        // Reset state
        check("rst_valid", 32'(tx_bus.tx_valid), 32'd0);
        check("rst_data", 32'(tx_bus.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(pkt_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step();

        // All-zero packet, full-rate sink
        build_expected();
        start_packet("t1");
        get_packet(0, -1, 122);
        compare_packet("t1");
        check("t1_chk_const", 32'(got[121]), 32'h00);
        check_done("t1");

        // Two grid cells and time_left
        zero_inputs();
        object_grid[0][0] = 4'd1;
        object_grid[0][1] = 4'd3;
        time_left = 8'd150;
        build_expected();
        start_packet("t2");
        get_packet(0, -1, 122);
        compare_packet("t2");
        check("t2_b17_const", 32'(got[17]), 32'h31);
        check("t2_b6_const", 32'(got[6]), 32'h96);
        check("t2_chk_const", 32'(got[121]), 32'hA7);
        check_done("t2");

        // Backpressure with position boundaries
        zero_inputs();
        player_loc_x = 9'h1FF;
        player_loc_y = 9'h100;
        build_expected();
        start_packet("t3");
        get_packet(1, -1, 122);
        compare_packet("t3");
        check("t3_b2_const", 32'(got[2]), 32'h01);
        check("t3_b3_const", 32'(got[3]), 32'hFF);
        check("t3_b4_const", 32'(got[4]), 32'h01);
        check("t3_b5_const", 32'(got[5]), 32'h00);
        check_done("t3");

        // Inputs change and send pulses mid-packet
        scramble_inputs();
        build_expected();
        start_packet("t4");
        get_packet(0, 60, 122);
        compare_packet("t4");
        check("t4_overrun", 32'(overrun), 32'd1);
        check_done("t4");
        repeat (5) step();
        check("t4_no_second", 32'(tx_bus.tx_valid), 32'd0);

        // Reset at byte 50, then a clean packet
        build_expected();
        start_packet("t5a");
        get_packet(0, -1, 50);
        reset = 1'b1;
        step();
        check("t5_abort_valid", 32'(tx_bus.tx_valid), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_overrun_clr", 32'(overrun), 32'd0);
        reset = 1'b0;
        step();
        scramble_inputs();
        build_expected();
        start_packet("t5");
        get_packet(0, -1, 122);
        compare_packet("t5");
        check_done("t5");
        check("t5_overrun", 32'(overrun), 32'd0);

        // Auto mode: packet start spacing and overrun
        n200 = 0; n100 = 0; p200 = 1'b0; p100 = 1'b0;
        for (int i = 0; i < 3; i++) begin s200[i] = 0; s100[i] = 0; end
        auto_reset = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            step();
            if (a200_bus.tx_valid && !p200 && n200 < 3) begin s200[n200] = cyc; n200++; end
            if (a100_bus.tx_valid && !p100 && n100 < 3) begin s100[n100] = cyc; n100++; end
            p200 = a200_bus.tx_valid;
            p100 = a100_bus.tx_valid;
        end
        check("a200_starts", 32'(n200), 32'd3);
        check("a200_gap1", 32'(s200[1] - s200[0]), 32'd200);
        check("a200_gap2", 32'(s200[2] - s200[1]), 32'd200);
        check("a200_overrun", 32'(a200_overrun), 32'd0);
        check("a100_starts", 32'(n100), 32'd3);
        check("a100_gap1", 32'(s100[1] - s100[0]), 32'd200);
        check("a100_gap2", 32'(s100[2] - s100[1]), 32'd200);
        check("a100_overrun", 32'(a100_overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_state_tx.md
Name: game_state_tx

Overview:
Packet transmitter that is the reader side of the game-logic state outputs. On a send request it snapshots the full game state (grids, timers, score, orders, team name, local player pose) and streams it as a fixed 122-byte packet. The stream uses a byte-wide valid/ready interface toward the link/UART block that carries state to the server and the other players. It gives the network path a stable, checksummed image of one clock's state.

Parameters:
PKT_LEN, 122, bytes per packet including header and checksum (fixed by format; not meant to be overridden)
HEADER, 8'hA5, first byte of every packet
AUTO_PERIOD, 0, if nonzero, internal send request every AUTO_PERIOD clock cycles; 0 disables auto mode

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
send  in  1  request a snapshot and transmit (level sampled each cycle)
local_player_ID  in  2  this board's player number
game_state  in  3  current game state
object_grid  in  [7:0][12:0][3:0]  object per cell
time_grid  in  [7:0][12:0][3:0]  timer per cell
time_left  in  8  seconds remaining
point_total  in  10  score
orders  in  4  active order flags
order_times  in  [3:0][4:0]  per-order timers
team_name  in  [2:0][7:0]  ASCII team name
player_direction  in  2  facing
player_loc_x  in  9  pixel x
player_loc_y  in  9  pixel y
player_state  in  4  carry/chop state
tx_data  out  8  stream byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready
busy  out  1  packet in progress (snapshot held)
pkt_done  out  1  one-cycle pulse after checksum byte accepted
overrun  out  1  sticky: a request arrived while busy

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, pkt_done=0, overrun=0. State is IDLE, byte index 0, checksum 0, auto counter 0.
- Reset mid-packet aborts immediately with no further bytes. The sink sees tx_valid drop.
- req = send OR auto_tick. auto_tick pulses when the auto counter reaches AUTO_PERIOD-1; the counter then wraps to 0. The counter runs in every state.
- IDLE, on req:
  - register every state input into the snapshot in that same cycle;
  - busy=1, go to SEND.
  - Next cycle: tx_valid=1, tx_data=HEADER.
  - Latency from req to first valid is 1 cycle.
- SEND:
  - tx_data/tx_valid are held stable while tx_valid && !tx_ready.
  - On a handshake, the index advances and the next byte is presented the following cycle.
  - Up to one byte per cycle is sent when tx_ready stays high.
- Byte map (snapshot values):
  - 0: HEADER
  - 1: {ID[1:0], game_state[2:0], 3'b0}
  - 2: {dir[1:0], player_state[3:0], 1'b0, loc_x[8]}
  - 3: loc_x[7:0]
  - 4: {7'b0, loc_y[8]}
  - 5: loc_y[7:0]
  - 6: time_left
  - 7: {6'b0, point_total[9:8]}
  - 8: point_total[7:0]
  - 9: {4'b0, orders}
  - 10..13: {3'b0, order_times[i]} for i=0..3
  - 14..16: team_name[2], [1], [0]
  - 17..68: object_grid. Cell n = row*13+col (0..103); byte 17+j = {cell[2j+1], cell[2j]}.
  - 69..120: time_grid, same packing.
  - 121: XOR of bytes 1..120.
- Checksum accumulates at each handshake for bytes 1..120. It clears when a packet starts.
- After byte 121 is accepted:
  - pkt_done=1 for one cycle, busy=0, tx_valid=0, return to IDLE.
  - A req in that same done cycle is accepted the next cycle.
- req while busy: ignored, the snapshot is unchanged, and overrun is set. overrun clears only on reset.
- Input changes during SEND never alter the outgoing bytes.

Decomposition:
- Package game_pkg:
  - HEADER, PKT_LEN, GRID_ROWS=8, GRID_COLS=13, and byte-offset constants (OFS_OBJ=17, OFS_TIME=69, OFS_CHK=121);
  - typedefs grid_t ([7:0][12:0][3:0]) and tx_state_t {IDLE, SEND}.
- One natural sub-module, packet_byte_mux: combinational snapshot + index -> byte. Keeps the sequencer small.

Test Plan:
- All inputs 0, send 1 cycle, tx_ready=1 -> bytes: 0xA5, then 120× 0x00, then checksum 0x00. 122 consecutive valid cycles, then pkt_done pulse; busy drops.
- object_grid[0][0]=1, [0][1]=3, time_left=150, rest 0 -> byte17=0x31, byte6=0x96, checksum=0xA7.
- Backpressure: tx_ready toggles 1-0-0-1 with loc_x=9'h1FF, loc_y=9'h100 -> bytes 2..5 = 0x01, 0xFF, 0x01, 0x00; data held stable during stalls; no byte duplicated or skipped.
- Change all inputs mid-packet -> output matches the original snapshot. send during busy sets overrun=1 and no second packet starts.
- Reset asserted at byte 50 -> tx_valid=0 next cycle. A subsequent send produces a full correct packet; overrun=0.
- AUTO_PERIOD=200, tx_ready=1 -> packets start 200 cycles apart. AUTO_PERIOD=100 -> overrun set; packets start on the first tick after each completion.
